vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Raster timing generator fed by the 25 MHz pixel strobe from the clock divider.
- Runs on the 100 MHz system clock and advances one pixel per strobe.
- Produces hsync/vsync for the VGA connector, plus active-area, pixel coordinates and line/frame strobes for the Snake renderer and game-tick logic.
- Defaults implement 640x480 @ 60 Hz.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- pix_stb  in  1  pixel enable, one clk wide, nominally every 4th clk
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- active  out  1  high while (x,y) is inside the visible area
- x  out  10  horizontal count, 0..H_TOTAL-1
- y  out  10  vertical count, 0..V_TOTAL-1
- line_end  out  1  one-clk pulse on the strobe that completes a line
- frame_end  out  1  one-clk pulse on the strobe that completes a frame

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Both must be ≤1024; elaboration fails otherwise.
- Counters h (10b) and v (10b) are registers; x = h, y = v directly.
- Reset (rst high at a clk edge):
  - h=0, v=0.
  - hsync=vsync=~SYNC_POL (inactive), active=1.
  - line_end=frame_end=0.
  - rst overrides pix_stb in the same cycle.
- pix_stb low: all registers hold; line_end=frame_end=0.
- pix_stb high, no rst:
  - If h<H_TOTAL-1, h<=h+1.
  - Else h<=0 and v advances: v<=v+1 if v<V_TOTAL-1, else v<=0.
- Sync and active outputs are registered and computed from the next-state (h,v), so they change on the same clk edge as x/y. No combinational path from counters to pins.
  - hsync = SYNC_POL when H_ACTIVE+H_FP ≤ h ≤ H_ACTIVE+H_FP+H_SYNC-1 (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP ≤ v ≤ V_ACTIVE+V_FP+V_SYNC-1 (490..491), else ~SYNC_POL.
  - active = (h<H_ACTIVE)&&(v<V_ACTIVE).
- Pulse outputs are combinational and valid in the same clk as the qualifying strobe:
  - line_end = pix_stb && h==H_TOTAL-1.
  - frame_end = pix_stb && h==H_TOTAL-1 && v==V_TOTAL-1.
  - Both are forced 0 while rst is high.
- pix_stb tied high is legal: the block advances every clk, giving one line per 800 clk.
- Irregular strobe spacing is tolerated; only the strobe count matters.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480 timing constants and derived H_TOTAL/V_TOTAL.
  - Coordinate width (10).
  - Polarity constant.
  - These are reused by the renderer and the snake grid mapper.
- One natural sub-module: vga_wrap_counter.
  - Parameterised modulus; inputs en and clr; outputs count and wrap.
  - Instantiated twice: h is enabled by pix_stb; v is enabled by the h wrap.

Test Plan:
- Reset: assert rst for 3 clk with pix_stb toggling -> x=0, y=0, hsync=vsync=1, active=1, line_end=frame_end=0 in every cycle.
- Divided strobe (pix_stb every 4th clk), 656 strobes after reset:
  - hsync=0 with x=656; active=0 already since x=640.
  - hsync returns to 1 at x=752, i.e. 96 strobes = 384 clk low.
- Line wrap: 800 strobes -> exactly one line_end pulse, one clk wide, coincident with the 800th strobe; next x=0, y=1.
- Full frame: 420000 strobes -> vsync low for exactly 1600 strobes (y=490..491); one frame_end pulse at the 420000th strobe; then x=0, y=0, active=1.
- Hold and mid-frame reset:
  - pix_stb low for 50 clk at (x=700, y=300) -> no change.
  - Assert rst with pix_stb high at (x=700, y=300) -> next clk x=0, y=0, hsync inactive, line_end=0.
- pix_stb tied high: hsync period = 800 clk; frame_end period = 420000 clk; no pulses dropped or doubled across 3 frames.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing package: 640x480@60 constants, coordinate width,
// sync polarity and a range helper reused by renderer and grid mapper.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL =
        VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL =
        VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // 0 = sync pulses are active-low
    localparam logic VGA_SYNC_POL = 1'b0;

    // Inclusive range test on a coordinate
    function automatic logic in_range(
        input logic [COORD_W-1:0] val,
        input int                 lo,
        input int                 hi
    );
        return (int'(val) >= lo) && (int'(val) <= hi);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-MOD counter with enable and synchronous clear.
// Ports: clk, i_clr, i_en -> o_count (registered), o_next, o_wrap.
module vga_wrap_counter #(
    parameter int MOD = 800,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_next,
    output logic         o_wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] r_count;

    // Wrap is qualified by enable so it doubles as a carry strobe
    assign o_wrap  = i_en && (r_count == LAST);
    assign o_count = r_count;

    always_comb begin
        o_next = r_count;
        if (i_clr)
            o_next = '0;
        else if (o_wrap)
            o_next = '0;
        else if (i_en)
            o_next = r_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        r_count <= o_next;
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator advancing one pixel per pix_stb.
// Ports: clk, rst, pix_stb -> hsync, vsync, active, x, y, line_end, frame_end.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_stb,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_end,
    output logic               frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = V_ACTIVE + V_FP + V_SYNC - 1;

    if (H_TOTAL > 1024) begin : g_h_too_big
        $error("vga_sync_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_too_big
        $error("vga_sync_gen: V_TOTAL exceeds 1024");
    end

    logic [COORD_W-1:0] w_h;
    logic [COORD_W-1:0] w_h_next;
    logic               w_h_wrap;
    logic [COORD_W-1:0] w_v;
    logic [COORD_W-1:0] w_v_next;
    logic               w_v_wrap;

    logic r_hsync;
    logic r_vsync;
    logic r_active;

    vga_wrap_counter #(
        .MOD (H_TOTAL),
        .W   (COORD_W)
    ) u_h_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_en    (pix_stb),
        .o_count (w_h),
        .o_next  (w_h_next),
        .o_wrap  (w_h_wrap)
    );

    // Vertical advances only on the strobe that ends a line
    vga_wrap_counter #(
        .MOD (V_TOTAL),
        .W   (COORD_W)
    ) u_v_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_en    (w_h_wrap),
        .o_count (w_v),
        .o_next  (w_v_next),
        .o_wrap  (w_v_wrap)
    );

    // Decode from next-state so pins move on the same edge as x/y
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync  <= ~SYNC_POL;
            r_vsync  <= ~SYNC_POL;
            r_active <= 1'b1;
        end else begin
            r_hsync  <= in_range(w_h_next, HS_LO, HS_HI) ?
                        SYNC_POL : ~SYNC_POL;
            r_vsync  <= in_range(w_v_next, VS_LO, VS_HI) ?
                        SYNC_POL : ~SYNC_POL;
            r_active <= in_range(w_h_next, 0, H_ACTIVE - 1) &&
                        in_range(w_v_next, 0, V_ACTIVE - 1);
        end
    end

    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign active    = r_active;
    assign x         = w_h;
    assign y         = w_v;
    assign line_end  = ~rst & w_h_wrap;
    assign frame_end = ~rst & w_h_wrap & w_v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: default 640x480 instance plus a
// small-geometry active-high instance so whole frames fit in a short run.
module tb_vga_sync_gen;

    localparam int F_HA = 640, F_HFP = 16, F_HS = 96, F_HBP = 48;
    localparam int F_VA = 480, F_VFP = 10, F_VS = 2, F_VBP = 33;
    localparam int F_HT = F_HA + F_HFP + F_HS + F_HBP;
    localparam int F_VT = F_VA + F_VFP + F_VS + F_VBP;

    localparam int S_HA = 16, S_HFP = 4, S_HS = 6, S_HBP = 4;
    localparam int S_VA = 6, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam int S_FT = S_HT * S_VT;

    localparam int TIED = 2500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic pix_stb = 1'b0;

    logic       f_hs, f_vs, f_act, f_le, f_fe;
    logic [9:0] f_x, f_y;
    logic       s_hs, s_vs, s_act, s_le, s_fe;
    logic [9:0] s_x, s_y;

    vga_sync_gen u_full (
        .clk       (clk),
        .rst       (rst),
        .pix_stb   (pix_stb),
        .hsync     (f_hs),
        .vsync     (f_vs),
        .active    (f_act),
        .x         (f_x),
        .y         (f_y),
        .line_end  (f_le),
        .frame_end (f_fe)
    );

    vga_sync_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .SYNC_POL (1'b1)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .pix_stb   (pix_stb),
        .hsync     (s_hs),
        .vsync     (s_vs),
        .active    (s_act),
        .x         (s_x),
        .y         (s_y),
        .line_end  (s_le),
        .frame_end (s_fe)
    );

    int     tests = 0;
    int     fails = 0;
    longint n = 0;       // strobes since last reset
    int     cyc_idx = 0;
    int     f_le_cnt = 0;
    int     f_hs_low = 0;
    int     s_vs_low = 0;
    logic   f_hs_prev = 1'b1;
    int     q_sfe[$];
    int     q_fle[$];
    int     q_fhs[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: position is simply the strobe count modulo the raster
    task automatic chk_geom(input string pfx, input int ha, input int hfp,
                            input int hs, input int ht, input int va,
                            input int vfp, input int vs, input int vt,
                            input logic pol, input logic [9:0] ox,
                            input logic [9:0] oy, input logic ohs,
                            input logic ovs, input logic oact);
        int h, v;
        logic ehs, evs;
        h = int'(n % ht);
        v = int'((n / ht) % vt);
        ehs = (h >= ha + hfp && h < ha + hfp + hs) ? pol : ~pol;
        evs = (v >= va + vfp && v < va + vfp + vs) ? pol : ~pol;
        chk({pfx, "_x"}, ox, h);
        chk({pfx, "_y"}, oy, v);
        chk({pfx, "_hsync"}, ohs, ehs);
        chk({pfx, "_vsync"}, ovs, evs);
        chk({pfx, "_active"}, oact, (h < ha && v < va) ? 1 : 0);
    endtask

    task automatic cyc(input logic stb, input logic r);
        logic fle, sle;
        @(negedge clk);
        pix_stb = stb;
        rst = r;
        #1;
        fle = !r && stb && (n % F_HT == F_HT - 1);
        sle = !r && stb && (n % S_HT == S_HT - 1);
        chk("f_line_end", f_le, fle);
        chk("f_frame_end", f_fe,
            fle && ((n / F_HT) % F_VT == F_VT - 1));
        chk("s_line_end", s_le, sle);
        chk("s_frame_end", s_fe,
            sle && ((n / S_HT) % S_VT == S_VT - 1));
        if (f_le === 1'b1) begin
            f_le_cnt++;
            q_fle.push_back(cyc_idx);
        end
        if (s_fe === 1'b1) q_sfe.push_back(cyc_idx);
        @(posedge clk);
        if (r) n = 0;
        else if (stb) n++;
        cyc_idx++;
        #1;
        chk_geom("f", F_HA, F_HFP, F_HS, F_HT, F_VA, F_VFP, F_VS, F_VT,
                 1'b0, f_x, f_y, f_hs, f_vs, f_act);
        chk_geom("s", S_HA, S_HFP, S_HS, S_HT, S_VA, S_VFP, S_VS, S_VT,
                 1'b1, s_x, s_y, s_hs, s_vs, s_act);
        if (f_hs === 1'b0) f_hs_low++;
        if (s_vs === 1'b1) s_vs_low++;
        if (f_hs_prev === 1'b1 && f_hs === 1'b0) q_fhs.push_back(cyc_idx);
        f_hs_prev = f_hs;
    endtask

    initial begin
        int exp_vs;
        int guard;

        // Reset held for 3 clk while the strobe toggles
        for (int i = 0; i < 3; i++) cyc(i[0], 1'b1);

        // Divided strobe: one pulse every 4th clk
        f_le_cnt = 0;
        f_hs_low = 0;
        for (int i = 0; i < 900; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 655) begin
                chk("div_x656", f_x, 656);
                chk("div_hsync_low", f_hs, 0);
                chk("div_active_off", f_act, 0);
            end
            if (i == 799) begin
                chk("wrap_x0", f_x, 0);
                chk("wrap_y1", f_y, 1);
                chk("wrap_le_count", f_le_cnt, 1);
            end
            for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
        end
        chk("div_hsync_low_clk", f_hs_low, 384);

        // Irregular strobes with rare resets
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);

        // Walk to x=700 then hold the strobe low
        guard = 0;
        while (n % F_HT != 700 && guard < 2 * F_HT) begin
            cyc(1'b1, 1'b0);
            guard++;
        end
        chk("reach_x700", f_x, 700);
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0);
            chk("hold_x", f_x, 700);
        end

        // Reset wins over a simultaneous strobe
        cyc(1'b1, 1'b1);
        chk("mid_rst_x", f_x, 0);
        chk("mid_rst_y", f_y, 0);
        chk("mid_rst_hsync", f_hs, 1);

        // Strobe tied high
        q_sfe.delete();
        q_fle.delete();
        q_fhs.delete();
        s_vs_low = 0;
        for (int i = 0; i < TIED; i++) cyc(1'b1, 1'b0);

        chk("tied_s_frames", q_sfe.size(), TIED / S_FT);
        for (int i = 1; i < q_sfe.size(); i++)
            chk("tied_s_fe_period", q_sfe[i] - q_sfe[i-1], S_FT);
        chk("tied_f_lines", q_fle.size(), TIED / F_HT);
        for (int i = 1; i < q_fle.size(); i++)
            chk("tied_f_le_period", q_fle[i] - q_fle[i-1], F_HT);
        chk("tied_f_hs_edges", q_fhs.size(), 3);
        for (int i = 1; i < q_fhs.size(); i++)
            chk("tied_f_hs_period", q_fhs[i] - q_fhs[i-1], F_HT);

        exp_vs = 0;
        for (int k = 1; k <= TIED; k++) begin
            int v;
            v = (k / S_HT) % S_VT;
            if (v >= S_VA + S_VFP && v < S_VA + S_VFP + S_VS) exp_vs++;
        end
        chk("tied_s_vsync_clk", s_vs_low, exp_vs);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
